// File: rtl/mbist_fail_logger.sv
// Fail-address logger for MBIST: records distinct failing {y,x} addresses in a FIFO,
// keeps a saturating fail count and sticky overflow, read back over the scan protocol.
module mbist_fail_logger #(
  parameter int ADDR_X = 3,
  parameter int ADDR_Y = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mbist_run,
  input  logic              fail_flag,
  input  logic [ADDR_X-1:0] addr_x,
  input  logic [ADDR_Y-1:0] addr_y,
  input  logic              select,
  input  logic              capture_en,
  input  logic              shift_en,
  input  logic              update_en,
  input  logic              si,
  output logic              so,
  output logic              log_empty,
  output logic              log_ovf
);

  localparam int EW   = ADDR_Y + ADDR_X;
  localparam int SR_W = 2 + CNT_W + EW;
  localparam int PW   = $clog2(DEPTH);

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      occ;
  logic [CNT_W-1:0] fail_cnt;
  logic             ovf;
  logic             last_valid;
  logic [EW-1:0]    last_entry;
  logic             run_q;
  logic [SR_W-1:0]  sr;

  logic          start;
  logic          log_event;
  logic          empty;
  logic          full;
  logic          dup;
  logic          do_cap;
  logic          do_shift;
  logic          do_pop;
  logic          do_push;
  logic          do_drop;
  logic [EW-1:0] entry;
  logic [EW-1:0] head;
  logic [PW-1:0] wr_idx;

  // A start behaves as if the FIFO were already cleared: no pop, no duplicate, never full.
  always_comb begin
    start     = mbist_run & ~run_q;
    log_event = mbist_run & fail_flag;
    entry     = {addr_y, addr_x};
    empty     = (occ == '0);
    full      = (occ == (PW+1)'(DEPTH));
    head      = empty ? '0 : mem[rd_ptr];
    do_cap    = select & capture_en;
    do_shift  = select & ~capture_en & shift_en;
    do_pop    = select & ~capture_en & ~shift_en & update_en & ~empty & ~start;
    dup       = last_valid & (entry == last_entry) & ~start;
    do_push   = log_event & ~dup & (~full | do_pop | start);
    do_drop   = log_event & ~dup & ~do_push;
    wr_idx    = start ? '0 : wr_ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= 1'b0;
      sr         <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      fail_cnt   <= '0;
      ovf        <= 1'b0;
      last_valid <= 1'b0;
      last_entry <= '0;
    end else begin
      run_q <= mbist_run;

      if (do_cap)
        sr <= {~empty, ovf, fail_cnt, head};
      else if (do_shift)
        sr <= {si, sr[SR_W-1:1]};

      if (start) begin
        rd_ptr     <= '0;
        wr_ptr     <= do_push ? PW'(1) : '0;
        occ        <= do_push ? (PW+1)'(1) : '0;
        fail_cnt   <= log_event ? CNT_W'(1) : '0;
        ovf        <= 1'b0;
        last_valid <= do_push;
      end else begin
        if (do_pop)
          rd_ptr <= rd_ptr + PW'(1);
        if (do_push)
          wr_ptr <= wr_ptr + PW'(1);
        if (do_push && !do_pop)
          occ <= occ + (PW+1)'(1);
        else if (do_pop && !do_push)
          occ <= occ - (PW+1)'(1);
        if (log_event && (fail_cnt != '1))
          fail_cnt <= fail_cnt + CNT_W'(1);
        if (do_drop)
          ovf <= 1'b1;
        if (do_push)
          last_valid <= 1'b1;
      end

      if (do_push)
        last_entry <= entry;
    end
  end

  // Storage array carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[wr_idx] <= entry;
  end

  assign so        = sr[0];
  assign log_empty = empty;
  assign log_ovf   = ovf;

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Self-checking bench for mbist_fail_logger: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_mbist_fail_logger;

  localparam int ADDR_X  = 3;
  localparam int ADDR_Y  = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int EW      = ADDR_Y + ADDR_X;
  localparam int SR_W    = 2 + CNT_W + EW;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              mbist_run;
  logic              fail_flag;
  logic [ADDR_X-1:0] addr_x;
  logic [ADDR_Y-1:0] addr_y;
  logic              select;
  logic              capture_en;
  logic              shift_en;
  logic              update_en;
  logic              si;
  logic              so;
  logic              log_empty;
  logic              log_ovf;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit run_lvl      = 1'b0;

  logic [EW-1:0]   m_q[$];
  int              m_cnt;
  bit              m_ovf;
  bit              m_lv;
  bit              m_runq;
  logic [EW-1:0]   m_last;
  logic [SR_W-1:0] m_sr;

  mbist_fail_logger #(
    .ADDR_X(ADDR_X), .ADDR_Y(ADDR_Y), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .mbist_run(mbist_run), .fail_flag(fail_flag),
    .addr_x(addr_x), .addr_y(addr_y), .select(select), .capture_en(capture_en),
    .shift_en(shift_en), .update_en(update_en), .si(si), .so(so),
    .log_empty(log_empty), .log_ovf(log_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the log is a plain queue, the counter a clamped integer.
  task automatic modelStep();
    logic [EW-1:0]   entry;
    logic [SR_W-1:0] word;
    bit st, cap, sh, up;
    if (rst) begin
      m_q.delete();
      m_cnt = 0; m_ovf = 0; m_lv = 0; m_runq = 0; m_last = '0; m_sr = '0;
      return;
    end
    entry = {addr_y, addr_x};
    st  = mbist_run && !m_runq;
    cap = select && capture_en;
    sh  = select && !capture_en && shift_en;
    up  = select && !capture_en && !shift_en && update_en;
    word = {m_q.size() != 0, m_ovf, CNT_W'(m_cnt), (m_q.size() != 0) ? m_q[0] : EW'(0)};
    if (cap) m_sr = word;
    else if (sh) m_sr = {si, m_sr[SR_W-1:1]};
    if (st) begin
      m_q.delete();
      m_cnt = 0; m_ovf = 0; m_lv = 0;
    end else if (up && m_q.size() > 0) begin
      m_q.delete(0);
    end
    if (mbist_run && fail_flag) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (!(m_lv && entry == m_last)) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(entry);
          m_last = entry;
          m_lv   = 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_runq = mbist_run;
  endtask

  task automatic applyStimulus(input bit r, input bit run, input bit fail, input int e,
                               input bit sel, input bit cap, input bit sh, input bit up,
                               input bit s_in);
    rst = r; mbist_run = run; fail_flag = fail; {addr_y, addr_x} = EW'(e);
    select = sel; capture_en = cap; shift_en = sh; update_en = up; si = s_in;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("so", so, m_sr[0]);
    checkOutput("log_empty", log_empty, m_q.size() == 0);
    checkOutput("log_ovf", log_ovf, m_ovf);
  endtask

  task automatic idle();
    applyStimulus(0, run_lvl, 0, 0, 0, 0, 0, 0, 1'($urandom));
  endtask

  task automatic logFail(input int e);
    applyStimulus(0, run_lvl, 1, e, 0, 0, 0, 0, 0);
  endtask

  task automatic popHead();
    applyStimulus(0, run_lvl, 0, 0, 1, 0, 0, 1, 0);
  endtask

  task automatic restart();
    run_lvl = 0;
    idle();
    run_lvl = 1;
    idle();
  endtask

  task automatic readWord(output logic [SR_W-1:0] w);
    applyStimulus(0, run_lvl, 0, 0, 1, 1, 0, 0, 0);
    w[0] = so;
    for (int i = 1; i < SR_W; i++) begin
      applyStimulus(0, run_lvl, 0, 0, 1, 0, 1, 0, 1'($urandom));
      w[i] = so;
    end
  endtask

  initial begin
    logic [SR_W-1:0] w;
    bit r;
    int e;

    // Reset held two cycles under random inputs
    for (int i = 0; i < 2; i++)
      applyStimulus(1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 127)), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    run_lvl = 0;
    idle();
    checkOutput("rst_so", so, 0);
    checkOutput("rst_empty", log_empty, 1);
    checkOutput("rst_ovf", log_ovf, 0);
    readWord(w);
    checkOutput("rst_word", w, 0);

    // Single fail at y=5, x=2
    restart();
    logFail(8'h2A);
    readWord(w);
    checkOutput("single_valid", w[16], 1);
    checkOutput("single_ovf", w[15], 0);
    checkOutput("single_cnt", w[14:7], 1);
    checkOutput("single_entry", w[6:0], 8'h2A);
    popHead();
    checkOutput("single_empty", log_empty, 1);
    readWord(w);
    checkOutput("single_valid2", w[16], 0);
    checkOutput("single_cnt2", w[14:7], 1);

    // Consecutive duplicates are counted but logged once
    restart();
    for (int i = 0; i < 3; i++) logFail(8'h09);
    logFail(8'h0A);
    readWord(w);
    checkOutput("dup_cnt", w[14:7], 4);
    checkOutput("dup_entry0", w[6:0], 8'h09);
    popHead();
    readWord(w);
    checkOutput("dup_entry1", w[6:0], 8'h0A);
    checkOutput("dup_valid1", w[16], 1);
    popHead();
    checkOutput("dup_empty", log_empty, 1);

    // Overflow: six distinct entries into four slots
    restart();
    for (int k = 1; k <= 6; k++) logFail(k);
    checkOutput("ovf_flag", log_ovf, 1);
    for (int k = 1; k <= 4; k++) begin
      readWord(w);
      checkOutput("ovf_entry", w[6:0], k);
      checkOutput("ovf_cnt", w[14:7], 6);
      checkOutput("ovf_bit", w[15], 1);
      popHead();
    end
    checkOutput("ovf_drained", log_empty, 1);

    // Concurrent pop and push on a full FIFO
    restart();
    for (int k = 1; k <= 4; k++) logFail(k);
    applyStimulus(0, 1, 1, 9, 1, 0, 0, 1, 0);
    checkOutput("full_pp_ovf", log_ovf, 0);
    for (int k = 0; k < 4; k++) begin
      readWord(w);
      checkOutput("full_pp_entry", w[6:0], (k < 3) ? k + 2 : 9);
      popHead();
    end
    checkOutput("full_pp_empty", log_empty, 1);

    // Counter saturation, then restart with a fail in the start cycle
    restart();
    for (int i = 0; i < 300; i++) logFail((i % 2) ? 2 : 1);
    readWord(w);
    checkOutput("sat_cnt", w[14:7], 255);
    checkOutput("sat_ovf", w[15], 1);
    run_lvl = 0;
    idle();
    run_lvl = 1;
    logFail(8'h7F);
    readWord(w);
    checkOutput("restart_cnt", w[14:7], 1);
    checkOutput("restart_ovf", w[15], 0);
    checkOutput("restart_valid", w[16], 1);
    checkOutput("restart_entry", w[6:0], 8'h7F);
    popHead();
    checkOutput("restart_empty", log_empty, 1);

    // Scan operations ignored while deselected; capture beats update
    restart();
    logFail(3);
    logFail(5);
    applyStimulus(0, 1, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 1, 0, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    checkOutput("gate_so", so, 1);
    checkOutput("gate_empty", log_empty, 0);
    applyStimulus(0, 1, 0, 0, 1, 1, 0, 1, 0);
    readWord(w);
    checkOutput("capupd_head", w[6:0], 3);
    popHead();
    readWord(w);
    checkOutput("capupd_next", w[6:0], 5);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) run_lvl = ~run_lvl;
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 3));
      applyStimulus(r, run_lvl, ($urandom_range(0, 2) == 0), e, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0), 1'($urandom), ($urandom_range(0, 4) == 0),
                    1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
